// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle controller: state encodings,
// opcodes, ALU control codes and ALU B-operand select encodings.
package multicycle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  // Opcodes live in instr[15:12]
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_ADDI = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;

  localparam logic [15:0] HALT_INSTR = 16'hFFFF;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_TWO    = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  // R-type instructions occupy the lowest seven opcodes
  function automatic logic is_rtype(input logic [3:0] op);
    return (op <= OP_SLT);
  endfunction

endpackage

// File: rtl/multicycle_alu_decode.sv
// Maps an R-type opcode to its ALU control code. Non-R-type opcodes
// fall back to add so the output is always defined.
module multicycle_alu_decode
  import multicycle_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic [3:0] alu_control_o
);

  // Pure lookup from opcode to ALU operation
  always_comb begin
    alu_control_o = ALU_ADD;
    case (opcode_i)
      OP_ADD:  alu_control_o = ALU_ADD;
      OP_SUB:  alu_control_o = ALU_SUB;
      OP_AND:  alu_control_o = ALU_AND;
      OP_OR:   alu_control_o = ALU_OR;
      OP_NOR:  alu_control_o = ALU_NOR;
      OP_NAND: alu_control_o = ALU_NAND;
      OP_SLT:  alu_control_o = ALU_SLT;
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for the 16-bit datapath:
// IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, HALT on 16'hFFFF.
// Outputs are decoded combinationally from the current state and instr.
// Optional build macro MULTICYCLE_MEM_WAIT_EN: MEM stalls until mem_ready.
module multicycle_controller
  import multicycle_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        ab_write,
  output logic        alu_out_write,
  output logic        mdr_write,
  output logic        reg_write,
  output logic        mem_write,
  output logic        mem_read,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_control,
  output logic        pc_source,
  output logic        halted,
  output logic [2:0]  state
);

  state_e     state_q, state_d;
  logic [3:0] opcode;
  logic [3:0] rtype_alu_ctl;
  logic       mem_done;

  assign opcode = instr[15:12];
  assign state  = state_q;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  // Memory always completes in one cycle; mem_ready is intentionally unused
  logic mem_ready_unused;
  assign mem_ready_unused = mem_ready;
  assign mem_done = 1'b1;
`endif

  multicycle_alu_decode u_alu_decode (
    .opcode_i      (opcode),
    .alu_control_o (rtype_alu_ctl)
  );

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and control decode; every output defaults to 0
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    ab_write      = 1'b0;
    alu_out_write = 1'b0;
    mdr_write     = 1'b0;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_control   = ALU_AND;
    pc_source     = 1'b0;
    halted        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // PC <= PC + 2 through the live ALU result
        ir_write    = 1'b1;
        pc_write    = 1'b1;
        alu_src_b   = SRC_B_TWO;
        alu_control = ALU_ADD;
        state_d     = ST_DECODE;
      end
      ST_DECODE: begin
        // Speculatively compute branch target into ALUOut
        ab_write      = 1'b1;
        alu_out_write = 1'b1;
        alu_src_b     = SRC_B_IMM_SH;
        alu_control   = ALU_ADD;
        if (instr == HALT_INSTR)  state_d = ST_HALT;
        else if (opcode >= 4'hC)  state_d = ST_FETCH;
        else                      state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (is_rtype(opcode)) begin
          alu_src_a     = 1'b1;
          alu_out_write = 1'b1;
          alu_control   = rtype_alu_ctl;
          state_d       = ST_WB;
        end else if (opcode == OP_ADDI || opcode == OP_LW || opcode == OP_SW) begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRC_B_IMM;
          alu_control   = ALU_ADD;
          alu_out_write = 1'b1;
          state_d       = (opcode == OP_ADDI) ? ST_WB : ST_MEM;
        end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
          // Compare A-B; taken branch loads PC from ALUOut
          alu_src_a   = 1'b1;
          alu_control = ALU_SUB;
          pc_source   = 1'b1;
          pc_write    = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
        end
      end
      ST_MEM: begin
        state_d = ST_FETCH;
        if (opcode == OP_LW) begin
          mem_read  = 1'b1;
          mdr_write = mem_done;
          state_d   = mem_done ? ST_WB : ST_MEM;
        end else if (opcode == OP_SW) begin
          mem_write = 1'b1;
          state_d   = mem_done ? ST_FETCH : ST_MEM;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype(opcode);
        mem_to_reg = (opcode == OP_LW);
        state_d    = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. The driver pushes the expected
// output vector for each cycle into exp_q; a monitor on the falling edge
// pops and compares it against the live DUT outputs.
module tb_multicycle_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, ab_write, alu_out_write, mdr_write;
  logic        reg_write, mem_write, mem_read, reg_dst, mem_to_reg;
  logic        alu_src_a, pc_source, halted;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_control;
  logic [2:0]  state;

  localparam int W = 22;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [W-1:0] act_vec;
  int           checks = 0;
  int           failures = 0;

  multicycle_controller dut (
    .clock(clock), .reset(reset), .start(start), .instr(instr), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .ab_write(ab_write), .alu_out_write(alu_out_write), .mdr_write(mdr_write),
    .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_source(pc_source),
    .halted(halted), .state(state)
  );

  // Clock
  always #5 clock = ~clock;

  assign act_vec = {state, pc_write, ir_write, ab_write, alu_out_write, mdr_write,
                    reg_write, mem_write, mem_read, reg_dst, mem_to_reg,
                    alu_src_a, alu_src_b, alu_control, pc_source, halted};

  function automatic logic [W-1:0] pk(input logic [2:0] st, input logic pcw, irw, abw,
      aow, mdrw, rw, mw, mr, rd, m2r, asa, input logic [1:0] asb,
      input logic [3:0] ac, input logic ps, h);
    return {st, pcw, irw, abw, aow, mdrw, rw, mw, mr, rd, m2r, asa, asb, ac, ps, h};
  endfunction

  // Expected vectors per state, written straight from the control table
  function automatic logic [W-1:0] e_idle();
    return pk(3'd0, 0,0,0,0,0,0,0,0,0,0, 0, 2'b00, 4'b0000, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_fetch();
    return pk(3'd1, 1,1,0,0,0,0,0,0,0,0, 0, 2'b01, 4'b0010, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_decode();
    return pk(3'd2, 0,0,1,1,0,0,0,0,0,0, 0, 2'b11, 4'b0010, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_exec_r(input logic [3:0] ac);
    return pk(3'd3, 0,0,0,1,0,0,0,0,0,0, 1, 2'b00, ac, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_exec_i();
    return pk(3'd3, 0,0,0,1,0,0,0,0,0,0, 1, 2'b10, 4'b0010, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_exec_br(input logic pcw);
    return pk(3'd3, pcw,0,0,0,0,0,0,0,0,0, 1, 2'b00, 4'b0110, 1, 0);
  endfunction
  function automatic logic [W-1:0] e_mem_lw(input logic mdr);
    return pk(3'd4, 0,0,0,0,mdr,0,0,1,0,0, 0, 2'b00, 4'b0000, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_mem_sw();
    return pk(3'd4, 0,0,0,0,0,0,1,0,0,0, 0, 2'b00, 4'b0000, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_wb(input logic rd, m2r);
    return pk(3'd5, 0,0,0,0,0,1,0,0,rd,m2r, 0, 2'b00, 4'b0000, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_halt();
    return pk(3'd6, 0,0,0,0,0,0,0,0,0,0, 0, 2'b00, 4'b0000, 0, 1);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (state got %0d expected %0d)",
               name, act, exp, act[W-1 -: 3], exp[W-1 -: 3]);
    end
  endtask

  // Scoreboard monitor: compare one expected vector per falling edge
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, act_vec, e);
    end
  end

  // Driver: queue this cycle's expectation and advance one clock
  task automatic cyc(input string name, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge clock);
    #1;
  endtask

  task automatic fetch_decode(input string tag, input logic [15:0] ins);
    instr = ins;
    cyc({tag, "_fetch"}, e_fetch());
    cyc({tag, "_decode"}, e_decode());
  endtask

  task automatic run_rtype(input string tag, input logic [15:0] ins, input logic [3:0] ac);
    fetch_decode(tag, ins);
    cyc({tag, "_exec"}, e_exec_r(ac));
    cyc({tag, "_wb"}, e_wb(1'b1, 1'b0));
  endtask

  task automatic run_branch(input string tag, input logic [15:0] ins, input logic z,
                            input logic pcw);
    zero = z;
    fetch_decode(tag, ins);
    cyc({tag, "_exec"}, e_exec_br(pcw));
    zero = 1'b0;
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    reset = 1'b1; start = 1'b0; instr = 16'h0000; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clock); #1;
    cyc("reset_state", e_idle());
    reset = 1'b0;
    cyc("idle_no_start", e_idle());
    start = 1'b1;
    instr = 16'h710F;
    cyc("idle_start", e_idle());
    start = 1'b0;

    // addi: 1,2,3,5
    fetch_decode("addi", 16'h710F);
    cyc("addi_exec", e_exec_i());
    cyc("addi_wb", e_wb(1'b0, 1'b0));

    // lw: 1,2,3,4,5
    fetch_decode("lw", 16'h8100);
    cyc("lw_exec", e_exec_i());
`ifdef MULTICYCLE_MEM_WAIT_EN
    mem_ready = 1'b0;
    cyc("lw_stall0", e_mem_lw(1'b0));
    cyc("lw_stall1", e_mem_lw(1'b0));
    cyc("lw_stall2", e_mem_lw(1'b0));
    mem_ready = 1'b1;
`endif
    cyc("lw_mem", e_mem_lw(1'b1));
    cyc("lw_wb", e_wb(1'b0, 1'b1));

    // sw: 1,2,3,4
    fetch_decode("sw", 16'h9100);
    cyc("sw_exec", e_exec_i());
    cyc("sw_mem", e_mem_sw());

    // branches
    run_branch("bne_nz", 16'hB6FC, 1'b0, 1'b1);
    run_branch("bne_z",  16'hB6FC, 1'b1, 1'b0);
    run_branch("beq_z",  16'hA000, 1'b1, 1'b1);
    run_branch("beq_nz", 16'hA000, 1'b0, 1'b0);

    // R-type ops
    run_rtype("add",  16'h0000, 4'b0010);
    run_rtype("nand", 16'h5000, 4'b1101);
    run_rtype("sub",  16'h1234, 4'b0110);
    run_rtype("slt",  16'h6000, 4'b0111);
    run_rtype("nor",  16'h4000, 4'b1100);

    // NOP returns straight to FETCH; start is ignored outside IDLE
    start = 1'b1;
    fetch_decode("nop", 16'hC123);
    start = 1'b0;

    // Reset asserted in the middle of EXEC
    fetch_decode("and", 16'h2000);
    exp_q.push_back(e_exec_r(4'b0000));
    name_q.push_back("and_exec");
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    check("reset_mid_exec", act_vec, e_idle());
    @(posedge clock); #1;
    cyc("reset_hold", e_idle());
    reset = 1'b0;
    cyc("idle_after_reset", e_idle());
    start = 1'b1;
    cyc("restart", e_idle());
    start = 1'b0;
    run_rtype("or", 16'h3000, 4'b0001);

    // HALT two cycles after fetch, then sticks even with start high
    fetch_decode("halt", 16'hFFFF);
    start = 1'b1;
    for (int i = 0; i < 10; i++) cyc($sformatf("halt_hold%0d", i), e_halt());
    start = 1'b0;
    reset = 1'b1;
    #1;
    check("reset_from_halt", act_vec, e_idle());
    @(posedge clock); #1;
    cyc("halt_reset_idle", e_idle());

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clock);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
